// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register scoreboard that generates the ID-stage freeze. Each tracked
//   register holds {valid, age, rlat} for its youngest in-flight writer. Age
//   counts pipeline advances since issue. The result becomes forwardable at
//   age == rlat, and it is written back (entry retired) at age == WB_LAT.
//
// Optional feature (macro HAZARD_PERF_EN):
//   stall_cycles  - saturating count of frozen, non-stalled, non-flushed edges
//   max_stall_run - longest consecutive freeze run, saturating
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           clears every entry; the concurrent issue is dropped
//   pipe_stall      holds ages and valids; blocks issue
//   forwarding_en   hazard only until rlat is reached (else until writeback)
//   id_valid        ID holds a valid instruction
//   rn_valid_id/rn_id, two_src_id/src_2_id   ID source operands
//   wb_en_id/dst_id/res_lat_id               ID destination and result latency
//   freeze          stall ID/IF and insert a bubble
//   busy_vec        per-register in-flight-writer flag
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned LAT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  pipe_stall,
  input  logic                  forwarding_en,
  input  logic                  id_valid,
  input  logic                  rn_valid_id,
  input  logic [REG_ADDR_W-1:0] rn_id,
  input  logic                  two_src_id,
  input  logic [REG_ADDR_W-1:0] src_2_id,
  input  logic                  wb_en_id,
  input  logic [REG_ADDR_W-1:0] dst_id,
  input  logic [LAT_W-1:0]      res_lat_id,
  output logic                  freeze,
  output logic [NUM_REGS-1:0]   busy_vec
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [LAT_W-1:0]      max_stall_run
`endif
);

  logic [NUM_REGS-1:0] valid_q, valid_d;
  logic [LAT_W-1:0]    age_q  [NUM_REGS];
  logic [LAT_W-1:0]    age_d  [NUM_REGS];
  logic [LAT_W-1:0]    rlat_q [NUM_REGS];
  logic [LAT_W-1:0]    rlat_d [NUM_REGS];

  logic                hazard_rn, hazard_s2;
  logic                issue;
  logic [LAT_W-1:0]    lat_clamped;

  // Indices at or above NUM_REGS never match a loop index, so they are
  // ignored for both the check and the issue.
  always_comb begin
    logic blocking;
    hazard_rn = 1'b0;
    hazard_s2 = 1'b0;
    blocking  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      blocking = valid_q[i] && (!forwarding_en || (age_q[i] < rlat_q[i]));
      if (rn_id == REG_ADDR_W'(i))    hazard_rn = blocking;
      if (src_2_id == REG_ADDR_W'(i)) hazard_s2 = blocking;
    end
  end

  // Only existing entries are checked, so a source equal to the same
  // instruction's destination never self-freezes.
  assign freeze = id_valid && ((rn_valid_id && hazard_rn) || (two_src_id && hazard_s2));

  assign issue = id_valid && wb_en_id && !freeze && !pipe_stall && !flush;

  always_comb begin
    if (res_lat_id == '0)                    lat_clamped = LAT_W'(1);
    else if (res_lat_id > LAT_W'(WB_LAT))    lat_clamped = LAT_W'(WB_LAT);
    else                                     lat_clamped = res_lat_id;
  end

  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    rlat_d  = rlat_q;
    if (flush) begin
      valid_d = '0;
    end else if (!pipe_stall) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (issue && (dst_id == REG_ADDR_W'(i))) begin
          // Youngest writer wins over the aging of any older entry.
          valid_d[i] = 1'b1;
          age_d[i]   = LAT_W'(1);
          rlat_d[i]  = lat_clamped;
        end else if (valid_q[i]) begin
          if (age_q[i] == LAT_W'(WB_LAT - 1)) valid_d[i] = 1'b0;
          else                                 age_d[i]   = age_q[i] + LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        age_q[i]  <= '0;
        rlat_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      rlat_q  <= rlat_d;
    end
  end

  assign busy_vec = valid_q;

`ifdef HAZARD_PERF_EN
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [LAT_W-1:0] run_q, run_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic             stall_count_en;

  assign stall_count_en = freeze && !pipe_stall && !flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_d       = run_q;
    if (stall_count_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    // A run ends on a flush or on an advancing edge without freeze;
    // a held pipeline neither extends nor ends it.
    if (flush || (!freeze && !pipe_stall)) run_d = '0;
    else if (stall_count_en && (run_q != '1)) run_d = run_q + LAT_W'(1);
    max_d = (run_d > max_q) ? run_d : max_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      run_q       <= '0;
      max_q       <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      max_q       <= max_d;
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign max_stall_run = max_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int AW = 4;
  localparam int NR = 12;
  localparam int WB = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n, flush, pipe_stall, forwarding_en;
  logic          id_valid, rn_valid_id, two_src_id, wb_en_id;
  logic [AW-1:0] rn_id, src_2_id, dst_id;
  logic [LW-1:0] res_lat_id;
  logic          freeze;
  logic [NR-1:0] busy_vec;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(
    .REG_ADDR_W (AW),
    .NUM_REGS   (NR),
    .WB_LAT     (WB),
    .LAT_W      (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .pipe_stall    (pipe_stall),
    .forwarding_en (forwarding_en),
    .id_valid      (id_valid),
    .rn_valid_id   (rn_valid_id),
    .rn_id         (rn_id),
    .two_src_id    (two_src_id),
    .src_2_id      (src_2_id),
    .wb_en_id      (wb_en_id),
    .dst_id        (dst_id),
    .res_lat_id    (res_lat_id),
    .freeze        (freeze),
    .busy_vec      (busy_vec)
  );

  always #5 clk = ~clk;

  // Reference model: each register remembers the pipeline-advance count at
  // which its youngest writer issued; age is the distance to the current count.
  bit known = 1'b0;
  int tick  = 0;
  bit m_live [NR];
  int m_itk  [NR];
  int m_rlat [NR];

  function automatic bit m_valid(int r);
    return (r < NR) && m_live[r] && ((tick - m_itk[r]) < WB);
  endfunction

  function automatic bit m_haz(int r);
    if (!m_valid(r)) return 1'b0;
    if (!forwarding_en) return 1'b1;
    return (tick - m_itk[r]) < m_rlat[r];
  endfunction

  function automatic bit exp_freeze();
    return id_valid && ((rn_valid_id && m_haz(int'(rn_id))) ||
                        (two_src_id && m_haz(int'(src_2_id))));
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] b;
    for (int r = 0; r < NR; r++) b[r] = m_valid(r);
    return b;
  endfunction

  function automatic int clamp(int x);
    if (x == 0) return 1;
    if (x > WB) return WB;
    return x;
  endfunction

  task automatic model_update(input bit ef);
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) m_live[r] = 1'b0;
      known = 1'b1;
    end else if (flush) begin
      for (int r = 0; r < NR; r++) m_live[r] = 1'b0;
    end else if (!pipe_stall) begin
      if (id_valid && wb_en_id && !ef && (int'(dst_id) < NR)) begin
        m_live[dst_id] = 1'b1;
        m_itk[dst_id]  = tick;
        m_rlat[dst_id] = clamp(int'(res_lat_id));
      end
      tick++;
    end
  endtask

  task automatic id_set(input bit iv, input bit rv, input int rn, input bit tv,
                        input int s2, input bit we, input int dst, input int rl);
    id_valid    = iv;
    rn_valid_id = rv;
    rn_id       = AW'(rn);
    two_src_id  = tv;
    src_2_id    = AW'(s2);
    wb_en_id    = we;
    dst_id      = AW'(dst);
    res_lat_id  = LW'(rl);
  endtask

  // Check current outputs against the model (and an optional constant
  // expectation for freeze), then advance one clock and update the model.
  task automatic cyc(input string tag, input int want_frz);
    bit            ef;
    logic [NR-1:0] eb;
    #1;
    ef = exp_freeze();
    eb = exp_busy();
    if (known) begin
      checks++;
      assert (freeze === ef) else begin
        errors++;
        $error("FAIL %s freeze observed=%b expected=%b", tag, freeze, ef);
      end
      checks++;
      assert (busy_vec === eb) else begin
        errors++;
        $error("FAIL %s busy_vec observed=%b expected=%b", tag, busy_vec, eb);
      end
      if (want_frz >= 0) begin
        checks++;
        assert (freeze === want_frz[0]) else begin
          errors++;
          $error("FAIL %s freeze_const observed=%b expected=%0d", tag, freeze, want_frz);
        end
      end
    end
    @(posedge clk);
    model_update(ef);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; pipe_stall = 1'b0; forwarding_en = 1'b1;
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc("reset0", -1);
    // Reset dominates a concurrent issue and flush.
    id_set(1, 0, 0, 0, 0, 1, 3, 1); flush = 1'b1;
    cyc("reset1", -1);
    rst_n = 1'b1; flush = 1'b0;
    id_set(1, 1, 3, 1, 3, 0, 0, 0);
    cyc("reset_state", 0);

    // Load-use with forwarding
    id_set(1, 0, 0, 0, 0, 1, 3, 2);  cyc("ld_issue", 0);
    id_set(1, 1, 3, 0, 0, 0, 0, 0);  cyc("ld_use1", 1);
    cyc("ld_use2", 0);
    id_set(0, 0, 0, 0, 0, 0, 0, 0);  cyc("idle1", 0);

    // ALU back-to-back with forwarding on src_2
    id_set(1, 0, 0, 0, 0, 1, 5, 1);  cyc("alu_issue", 0);
    id_set(1, 0, 0, 1, 5, 0, 0, 0);  cyc("alu_use", 0);

    // No forwarding: dependent waits until writeback
    forwarding_en = 1'b0;
    id_set(1, 0, 0, 0, 0, 1, 7, 1);  cyc("nf_issue", 0);
    id_set(1, 1, 7, 0, 0, 0, 0, 0);
    cyc("nf_use1", 1); cyc("nf_use2", 1); cyc("nf_use3", 1); cyc("nf_rel", 0);
    forwarding_en = 1'b1;

    // pipe_stall while a load is at age 1
    id_set(1, 0, 0, 0, 0, 1, 2, 2);  cyc("st_issue", 0);
    id_set(1, 1, 2, 0, 0, 1, 6, 1);
    pipe_stall = 1'b1;
    for (int i = 0; i < 4; i++) cyc("st_hold", 1);
    pipe_stall = 1'b0;
    cyc("st_rel1", 1);
    id_set(1, 1, 2, 0, 0, 0, 0, 0);
    cyc("st_rel2", 0);

    // Flush with entries in flight plus a concurrent issue
    id_set(1, 0, 0, 0, 0, 1, 1, 3);  cyc("fl_i1", 0);
    id_set(1, 0, 0, 0, 0, 1, 4, 3);  cyc("fl_i4", 0);
    id_set(1, 0, 0, 0, 0, 1, 9, 3);  cyc("fl_i9", 0);
    id_set(1, 0, 0, 0, 0, 1, 6, 3);  flush = 1'b1; pipe_stall = 1'b1;
    cyc("fl_edge", 0);
    flush = 1'b0; pipe_stall = 1'b0;
    #1;
    checks++;
    assert (busy_vec === '0) else begin
      errors++;
      $error("FAIL fl_busy busy_vec observed=%b expected=0", busy_vec);
    end
    forwarding_en = 1'b0;
    id_set(1, 1, 6, 1, 1, 0, 0, 0);  cyc("fl_after", 0);
    forwarding_en = 1'b1;

    // Same-register reissue: youngest writer wins
    id_set(1, 0, 0, 0, 0, 1, 8, 3);  cyc("re_i1", 0);
    id_set(1, 0, 0, 0, 0, 1, 8, 1);  cyc("re_i2", 0);
    id_set(1, 1, 8, 0, 0, 0, 0, 0);  cyc("re_use", 0);

    // Source equals own destination; out-of-range indices; clamp of 0 and 7
    id_set(1, 1, 10, 1, 10, 1, 10, 0); cyc("self", 0);
    id_set(1, 0, 0, 0, 0, 1, 11, 7);   cyc("clamp_hi", -1);
    id_set(1, 1, 11, 0, 0, 0, 0, 0);   cyc("clamp_use", 1);
    forwarding_en = 1'b0;
    id_set(1, 0, 0, 0, 0, 1, 13, 1);   cyc("oor_issue", 0);
    id_set(1, 1, 13, 1, 15, 0, 0, 0);  cyc("oor_use", 0);
    forwarding_en = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 127) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      pipe_stall    = ($urandom_range(0, 4) == 0);
      forwarding_en = ($urandom_range(0, 3) != 0);
      id_set($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 2) != 0,
             $urandom_range(0, 15), $urandom_range(0, 7));
      cyc("rand", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
